// File: rtl/acc_core_fsm_if.sv
// Program-load port, run/halt handshake and core status for acc_core_fsm.
// carry_out is present only when CARRY_EN is defined.
interface acc_core_fsm_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    localparam int INSTR_W = 4 + ADDR_W;

    logic               prog_we;
    logic [ADDR_W-1:0]  prog_addr;
    logic [INSTR_W-1:0] prog_data;
    logic               run;
    logic [DATA_W-1:0]  acc_out;
    logic [ADDR_W-1:0]  pc_out;
    logic               busy;
    logic               halted;
`ifdef CARRY_EN
    logic               carry_out;
`endif

    modport master (
        output prog_we, prog_addr, prog_data, run,
`ifdef CARRY_EN
        input  carry_out,
`endif
        input  acc_out, pc_out, busy, halted
    );

    modport slave (
        input  prog_we, prog_addr, prog_data, run,
`ifdef CARRY_EN
        output carry_out,
`endif
        output acc_out, pc_out, busy, halted
    );
endinterface

// File: rtl/acc_core_fsm.sv
// Multi-cycle accumulator core: FETCH/EXEC state machine with its own program and data RAM.
// Optional CARRY_EN adds a carry flag, ADC (opcode D), BC (opcode E) and carry_out.
module acc_core_fsm #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input logic           clk,
    input logic           rst,
    acc_core_fsm_if.slave bus
);
    localparam int INSTR_W = 4 + ADDR_W;
    localparam int DEPTH   = 1 << ADDR_W;

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

    typedef enum logic [3:0] {
        OP_NOP, OP_LDI, OP_LD, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR,
        OP_XOR, OP_SHL, OP_JMP, OP_BZ, OP_BNZ, OP_ADC, OP_BC, OP_HALT
    } opcode_t;

    state_t             state;
    logic [DATA_W-1:0]  acc;
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] ir;
    logic               zero;
    logic               busy_q;
    logic               halted_q;

    logic [INSTR_W-1:0] prog_mem [DEPTH];
    logic [DATA_W-1:0]  data_mem [DEPTH];

    opcode_t            op;
    logic [ADDR_W-1:0]  opa;
    logic [DATA_W-1:0]  operand;
    logic [DATA_W-1:0]  acc_nxt;
    logic [ADDR_W-1:0]  pc_nxt;
    logic               halt_op;
    logic               load_ok;
    logic               dmem_we;

`ifdef CARRY_EN
    logic               carry;
    logic               carry_nxt;
    logic [DATA_W:0]    add_w;
    logic [DATA_W:0]    sub_w;
    logic [DATA_W:0]    adc_w;

    // The extra top bit of each wide result is the carry (or borrow for SUB).
    assign add_w = {1'b0, acc} + {1'b0, operand};
    assign sub_w = {1'b0, acc} - {1'b0, operand};
    assign adc_w = {1'b0, acc} + {1'b0, operand} + (DATA_W+1)'(carry);
    assign bus.carry_out = carry;
`endif

    assign op       = opcode_t'(ir[INSTR_W-1:ADDR_W]);
    assign opa      = ir[ADDR_W-1:0];
    assign operand  = data_mem[opa];
    assign load_ok  = (state == IDLE) || (state == HALT);
    assign dmem_we  = (state == EXEC) && (op == OP_ST);

    assign bus.acc_out = acc;
    assign bus.pc_out  = pc;
    assign bus.busy    = busy_q;
    assign bus.halted  = halted_q;

    always_comb begin
        acc_nxt = acc;
        pc_nxt  = pc + ADDR_W'(1);
        halt_op = 1'b0;
`ifdef CARRY_EN
        carry_nxt = carry;
`endif
        case (op)
            OP_LDI: acc_nxt = DATA_W'(opa);
            OP_LD:  acc_nxt = operand;
`ifdef CARRY_EN
            OP_ADD: {carry_nxt, acc_nxt} = add_w;
            OP_SUB: {carry_nxt, acc_nxt} = sub_w;
            OP_ADC: {carry_nxt, acc_nxt} = adc_w;
            OP_BC:  if (carry) pc_nxt = opa;
`else
            OP_ADD: acc_nxt = acc + operand;
            OP_SUB: acc_nxt = acc - operand;
`endif
            OP_AND: acc_nxt = acc & operand;
            OP_OR:  acc_nxt = acc | operand;
            OP_XOR: acc_nxt = acc ^ operand;
            OP_SHL: acc_nxt = {acc[DATA_W-2:0], 1'b0};
            OP_JMP: pc_nxt = opa;
            // zero mirrors acc before this EXEC, which is what branches must test
            OP_BZ:  if (zero) pc_nxt = opa;
            OP_BNZ: if (!zero) pc_nxt = opa;
            OP_HALT: begin
                pc_nxt  = pc;
                halt_op = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            acc      <= '0;
            pc       <= '0;
            ir       <= '0;
            zero     <= 1'b1;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
`ifdef CARRY_EN
            carry    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, HALT: begin
                    if (bus.run) begin
                        state    <= FETCH;
                        acc      <= '0;
                        pc       <= '0;
                        zero     <= 1'b1;
                        busy_q   <= 1'b1;
                        halted_q <= 1'b0;
`ifdef CARRY_EN
                        carry    <= 1'b0;
`endif
                    end
                end
                FETCH: begin
                    ir    <= prog_mem[pc];
                    state <= EXEC;
                end
                EXEC: begin
                    acc  <= acc_nxt;
                    zero <= (acc_nxt == '0);
                    pc   <= pc_nxt;
`ifdef CARRY_EN
                    carry <= carry_nxt;
`endif
                    if (halt_op) begin
                        state    <= HALT;
                        busy_q   <= 1'b0;
                        halted_q <= 1'b1;
                    end else begin
                        state <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // RAMs are never cleared; reset only blocks writes in its cycle.
    always_ff @(posedge clk) begin
        if (rst && load_ok && bus.prog_we)
            prog_mem[bus.prog_addr] <= bus.prog_data;
        if (rst && dmem_we)
            data_mem[opa] <= acc;
    end
endmodule

// File: tb/tb_acc_core_fsm.sv
// Randomized self-checking bench for acc_core_fsm against an instruction-level interpreter.
// Build with CARRY_EN defined to exercise the carry, ADC and BC paths.
module tb_acc_core_fsm;
    logic clk = 1'b0;
    logic rst;

    acc_core_fsm_if #(.DATA_W(8), .ADDR_W(4)) bus ();

    acc_core_fsm #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [7:0] prog_q [$];
    logic [7:0] model_prog [16];
    logic [7:0] cand [16];
    int         model_dmem [16];
    int         exp_acc, exp_pc, exp_carry, exp_n;
    bit         exp_ok;
    int         cycles;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Instruction-level interpreter over cand; data memory is committed only if HALT is reached.
    task automatic modelRun(input int max_instr);
        int d [16];
        int acc, pc, c, n, op, a, nxt, t;
        logic [7:0] w;
        d = model_dmem;
        acc = 0; pc = 0; c = 0; n = 0;
        exp_ok = 1'b0;
        while (n < max_instr && !exp_ok) begin
            w   = cand[pc];
            op  = int'(w[7:4]);
            a   = int'(w[3:0]);
            n++;
            nxt = (pc + 1) % 16;
            case (op)
                1:  acc = a;
                2:  acc = d[a];
                3:  d[a] = acc;
                4:  begin t = acc + d[a]; c = (t > 255) ? 1 : 0; acc = t % 256; end
                5:  begin c = (acc < d[a]) ? 1 : 0; acc = (acc - d[a] + 256) % 256; end
                6:  acc = acc & d[a];
                7:  acc = acc | d[a];
                8:  acc = acc ^ d[a];
                9:  acc = (acc * 2) % 256;
                10: nxt = a;
                11: if (acc == 0) nxt = a;
                12: if (acc != 0) nxt = a;
`ifdef CARRY_EN
                13: begin t = acc + d[a] + c; c = (t > 255) ? 1 : 0; acc = t % 256; end
                14: if (c == 1) nxt = a;
`endif
                15: begin exp_ok = 1'b1; nxt = pc; end
                default: ;
            endcase
            pc = nxt;
        end
        exp_acc = acc; exp_pc = pc; exp_carry = c; exp_n = n;
        if (exp_ok) model_dmem = d;
    endtask

    task automatic loadProgram();
        foreach (prog_q[i]) begin
            @(negedge clk);
            bus.prog_we   = 1'b1;
            bus.prog_addr = 4'(i);
            bus.prog_data = prog_q[i];
            model_prog[i] = prog_q[i];
        end
        @(negedge clk);
        bus.prog_we = 1'b0;
    endtask

    task automatic applyStimulus(input string tag, input bit poke);
        @(negedge clk);
        bus.run = 1'b1;
        @(negedge clk);
        bus.run = 1'b0;
        checkOutput({tag, "_busy_start"}, 32'(bus.busy), 32'd1);
        cycles = 0;
        while (!bus.halted && cycles < 200) begin
            if (poke) begin
                bus.prog_we   = 1'($urandom_range(0, 1));
                bus.prog_addr = 4'($urandom);
                bus.prog_data = 8'($urandom);
                bus.run       = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            cycles++;
        end
        bus.prog_we = 1'b0;
        bus.run     = 1'b0;
    endtask

    task automatic runProgram(input string tag, input bit poke);
        applyStimulus(tag, poke);
        if (cycles >= 200) begin
            checkOutput({tag, "_timeout"}, 32'(cycles), 32'(2 * exp_n));
            rst = 1'b0;
            @(negedge clk);
            rst = 1'b1;
            return;
        end
        checkOutput({tag, "_cycles"}, 32'(cycles), 32'(2 * exp_n));
        checkOutput({tag, "_acc"}, 32'(bus.acc_out), 32'(exp_acc));
        checkOutput({tag, "_pc"}, 32'(bus.pc_out), 32'(exp_pc));
        checkOutput({tag, "_halted"}, 32'(bus.halted), 32'd1);
        checkOutput({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
`ifdef CARRY_EN
        checkOutput({tag, "_carry"}, 32'(bus.carry_out), 32'(exp_carry));
`endif
    endtask

    task automatic runLoaded(input string tag, input bit poke);
        loadProgram();
        cand = model_prog;
        modelRun(80);
        runProgram(tag, poke);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b0;
        bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0; bus.run = 1'b0;
        foreach (model_prog[i]) model_prog[i] = 8'h00;
        foreach (model_dmem[i]) model_dmem[i] = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("reset_acc", 32'(bus.acc_out), 32'd0);
        checkOutput("reset_pc", 32'(bus.pc_out), 32'd0);
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_halted", 32'(bus.halted), 32'd0);
`ifdef CARRY_EN
        checkOutput("reset_carry", 32'(bus.carry_out), 32'd0);
`endif

        $display("[TB] directed programs");
        prog_q = '{8'h15, 8'h32, 8'h13, 8'h42, 8'hF0};
        runLoaded("add", 1'b0);
        checkOutput("add_const_acc", 32'(bus.acc_out), 32'd8);
        checkOutput("add_const_pc", 32'(bus.pc_out), 32'd4);
        checkOutput("add_const_cycles", 32'(cycles), 32'd10);

        prog_q = '{8'h11, 8'h31, 8'h10, 8'h51, 8'hF0};
        runLoaded("subwrap", 1'b0);
        checkOutput("subwrap_const_acc", 32'(bus.acc_out), 32'hFF);

        prog_q = '{8'h1F, 8'h90, 8'h90, 8'h90, 8'h90, 8'hF0};
        runLoaded("shl", 1'b0);
        checkOutput("shl_const_acc", 32'(bus.acc_out), 32'hF0);

        prog_q = '{8'h13, 8'h30, 8'h11, 8'h31, 8'h20, 8'h51, 8'h30, 8'hC4, 8'hF0};
        runLoaded("loop", 1'b1);
        checkOutput("loop_const_acc", 32'(bus.acc_out), 32'd0);
        checkOutput("loop_const_cycles", 32'(cycles), 32'd34);
        checkOutput("loop_const_pc", 32'(bus.pc_out), 32'd8);

        // Stop the loop while SUB of the second iteration is in EXEC.
        @(negedge clk); bus.run = 1'b1;
        @(negedge clk); bus.run = 1'b0;
        repeat (19) @(negedge clk);
        checkOutput("midrun_pc", 32'(bus.pc_out), 32'd5);
        checkOutput("midrun_acc", 32'(bus.acc_out), 32'd2);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrun_reset_acc", 32'(bus.acc_out), 32'd0);
        checkOutput("midrun_reset_pc", 32'(bus.pc_out), 32'd0);
        checkOutput("midrun_reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("midrun_reset_halted", 32'(bus.halted), 32'd0);
        rst = 1'b1;
        cand = model_prog;
        modelRun(80);
        runProgram("rerun", 1'b0);
        checkOutput("rerun_const_acc", 32'(bus.acc_out), 32'd0);

        prog_q = '{8'h1F, 8'h90, 8'h90, 8'h90, 8'h90, 8'h30, 8'h40, 8'hE9, 8'hF0, 8'h17, 8'hF0};
        runLoaded("carry", 1'b0);
`ifdef CARRY_EN
        checkOutput("carry_const_acc", 32'(bus.acc_out), 32'd7);
        checkOutput("carry_const_flag", 32'(bus.carry_out), 32'd1);
        checkOutput("carry_const_pc", 32'(bus.pc_out), 32'd10);
`else
        checkOutput("carry_const_acc", 32'(bus.acc_out), 32'hE0);
        checkOutput("carry_const_pc", 32'(bus.pc_out), 32'd8);
`endif

        $display("[TB] seeding data memory");
        for (int a = 0; a < 16; a++) begin
            prog_q = '{8'h10 | 8'($urandom_range(0, 15)), 8'h90, 8'h90, 8'h30 | 8'(a), 8'hF0};
            runLoaded("seed", 1'b0);
        end

        $display("[TB] random programs");
        for (int r = 0; r < 25; r++) begin
            int tries = 0;
            do begin
                for (int k = 0; k < 16; k++) begin
                    int op = int'($urandom_range(0, 15));
                    if ($urandom_range(0, 5) == 0) op = 15;
                    cand[k] = {4'(op), 4'($urandom)};
                end
                modelRun(60);
                tries++;
            end while (!exp_ok && tries < 1000);
            if (exp_ok) begin
                prog_q.delete();
                for (int k = 0; k < 16; k++) prog_q.push_back(cand[k]);
                loadProgram();
                runProgram("random", 1'b1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
